// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
// Direct-mapped instruction cache, one 32-bit word per line, sitting between
// the instruction fetcher and the memory controller. Hits answer one cycle
// after the request; misses issue a single word read to the memory controller
// and answer one cycle after it completes. A ROB rollback aborts whatever
// fetch is in flight without invalidating any cached lines.
//
// Ports
//   clk                  system clock, rising-edge
//   rst                  asynchronous active-high reset
//   rob_rollback_in      misprediction flush
//   fet_request_in       fetcher request, held until fet_ready_out
//   fet_address_in       fetch PC (bits [1:0] ignored, only [17:2] looked up)
//   fet_ready_out        one-cycle pulse, fet_instruction_out valid
//   fet_instruction_out  instruction word for the accepted request
//   mc_request_out       word-read request to memory controller
//   mc_address_out       word-aligned miss address
//   mc_ready_in          memory controller read-complete pulse
//   mc_instruction_in    fetched word, valid with mc_ready_in
// -----------------------------------------------------------------------------
module instruction_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rob_rollback_in,
    input  logic        fet_request_in,
    input  logic [31:0] fet_address_in,
    output logic        fet_ready_out,
    output logic [31:0] fet_instruction_out,
    output logic        mc_request_out,
    output logic [31:0] mc_address_out,
    input  logic        mc_ready_in,
    input  logic [31:0] mc_instruction_in
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 16 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESPOND
    } state_e;

    state_e                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tagMem  [LINES];
    logic [31:0]           dataMem [LINES];

    // Word address of the outstanding miss; index and tag for the fill are
    // recovered from it, so no separate index/tag registers are needed.
    logic [29:0]           missAddr_q, missAddr_d;
    logic [31:0]           fetInstr_q, fetInstr_d;

    logic [INDEX_BITS-1:0] lookupIndex;
    logic [TAG_BITS-1:0]   lookupTag;
    logic [INDEX_BITS-1:0] missIndex;
    logic [TAG_BITS-1:0]   missTag;
    logic                  lookupHit;
    logic                  fillEn;
    logic                  unused_addr_bits;

    assign lookupIndex      = fet_address_in[INDEX_BITS+1:2];
    assign lookupTag        = fet_address_in[17:INDEX_BITS+2];
    assign missIndex        = missAddr_q[INDEX_BITS-1:0];
    assign missTag          = missAddr_q[15:INDEX_BITS];
    assign lookupHit        = valid_q[lookupIndex] && (tagMem[lookupIndex] == lookupTag);
    assign unused_addr_bits = ^fet_address_in[1:0];

    // A fill only happens if the returning word is still wanted; a rollback
    // in the same cycle discards it entirely.
    assign fillEn = (state_q == MISS) && mc_ready_in && !rob_rollback_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and valid bits; valid bits are only ever set here,
    // never cleared except by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            missAddr_q <= '0;
            fetInstr_q <= '0;
        end else begin
            missAddr_q <= missAddr_d;
            fetInstr_q <= fetInstr_d;
            if (fillEn) begin
                valid_q[missIndex] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagMem[missIndex]  <= missTag;
            dataMem[missIndex] <= mc_instruction_in;
        end
    end

    // Next-state logic; rollback overrides everything, including a
    // simultaneous lookup or memory return.
    always_comb begin
        state_d    = state_q;
        missAddr_d = missAddr_q;
        fetInstr_d = fetInstr_q;
        if (rob_rollback_in) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fet_request_in) begin
                        if (lookupHit) begin
                            fetInstr_d = dataMem[lookupIndex];
                            state_d    = RESPOND;
                        end else begin
                            missAddr_d = fet_address_in[31:2];
                            state_d    = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_ready_in) begin
                        fetInstr_d = mc_instruction_in;
                        state_d    = RESPOND;
                    end
                end
                RESPOND: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        fet_ready_out       = (state_q == RESPOND);
        mc_request_out      = (state_q == MISS);
        mc_address_out      = {missAddr_q, 2'b00};
        fet_instruction_out = fetInstr_q;
    end

endmodule

// File: tb/tb_instruction_cache.sv
// -----------------------------------------------------------------------------
// tb_instruction_cache
// Self-checking bench for instruction_cache. A line-level model (valid/tag/data
// per index, computed with plain arithmetic on the address) predicts hit or
// miss for every fetch; directed scenarios cover reset, cold miss, hit,
// conflict eviction, rollbacks and held requests, followed by randomized
// fetches with address aliasing in the ignored upper bits.
// -----------------------------------------------------------------------------
module tb_instruction_cache;

    localparam int IB = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_rollback_in;
    logic        fet_request_in;
    logic [31:0] fet_address_in;
    logic        fet_ready_out;
    logic [31:0] fet_instruction_out;
    logic        mc_request_out;
    logic [31:0] mc_address_out;
    logic        mc_ready_in;
    logic [31:0] mc_instruction_in;

    int errors = 0;
    int checks = 0;

    bit          modelValid [64];
    int unsigned modelTag   [64];
    logic [31:0] modelData  [64];

    instruction_cache #(.INDEX_BITS(IB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rob_rollback_in     (rob_rollback_in),
        .fet_request_in      (fet_request_in),
        .fet_address_in      (fet_address_in),
        .fet_ready_out       (fet_ready_out),
        .fet_instruction_out (fet_instruction_out),
        .mc_request_out      (mc_request_out),
        .mc_address_out      (mc_address_out),
        .mc_ready_in         (mc_ready_in),
        .mc_instruction_in   (mc_instruction_in)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lineOf(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] a);
        return int'((a >> 8) % 1024);
    endfunction

    // One complete fetch transaction; the model decides whether it must hit
    task automatic fetch(input logic [31:0] addr, input int delay,
                         input logic [31:0] memWord, input string name);
        int          li        = lineOf(addr);
        bit          expectHit = modelValid[li] && (modelTag[li] == tagOf(addr));
        logic [31:0] expAddr   = addr & 32'hFFFF_FFFC;
        fet_address_in = addr;
        fet_request_in = 1'b1;
        step();
        if (expectHit) begin
            checks++;
            if (fet_ready_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s hit ready: got %b want 1", name, fet_ready_out);
            end
            checks++;
            if (fet_instruction_out !== modelData[li]) begin
                errors++;
                $display("[TB] FAIL %s hit data: got %h want %h", name, fet_instruction_out, modelData[li]);
            end
            checks++;
            if (mc_request_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s hit mc_request: got %b want 0", name, mc_request_out);
            end
        end else begin
            checks++;
            if (mc_request_out !== 1'b1 || fet_ready_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s miss start: mc_req=%b ready=%b want 1/0", name, mc_request_out, fet_ready_out);
            end
            checks++;
            if (mc_address_out !== expAddr) begin
                errors++;
                $display("[TB] FAIL %s miss addr: got %h want %h", name, mc_address_out, expAddr);
            end
            for (int i = 0; i < delay; i++) begin
                step();
                checks++;
                if (mc_request_out !== 1'b1 || mc_address_out !== expAddr || fet_ready_out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s miss hold: mc_req=%b addr=%h ready=%b want 1/%h/0",
                             name, mc_request_out, mc_address_out, fet_ready_out, expAddr);
                end
            end
            mc_ready_in       = 1'b1;
            mc_instruction_in = memWord;
            step();
            mc_ready_in       = 1'b0;
            mc_instruction_in = $urandom;
            checks++;
            if (fet_ready_out !== 1'b1 || mc_request_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s fill respond: ready=%b mc_req=%b want 1/0", name, fet_ready_out, mc_request_out);
            end
            checks++;
            if (fet_instruction_out !== memWord) begin
                errors++;
                $display("[TB] FAIL %s fill data: got %h want %h", name, fet_instruction_out, memWord);
            end
            modelValid[li] = 1'b1;
            modelTag[li]   = tagOf(addr);
            modelData[li]  = memWord;
        end
        fet_request_in = 1'b0;
        step();
        checks++;
        if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s back to idle: ready=%b mc_req=%b want 0/0", name, fet_ready_out, mc_request_out);
        end
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        rob_rollback_in   = 1'b0;
        fet_request_in    = 1'b0;
        fet_address_in    = '0;
        mc_ready_in       = 1'b0;
        mc_instruction_in = '0;
        for (int i = 0; i < 64; i++) modelValid[i] = 1'b0;
        #12;
        checks++;
        if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset strobes: ready=%b mc_req=%b want 0/0", fet_ready_out, mc_request_out);
        end
        checks++;
        if (fet_instruction_out !== 32'h0 || mc_address_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset data: instr=%h addr=%h want 0/0", fet_instruction_out, mc_address_out);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_0004, 5, 32'h0040_0093, "cold_miss");
    endtask

    task automatic test_hit();
        fetch(32'h0000_0004, 0, 32'hDEAD_BEEF, "hit");
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0000, 2, 32'h1111_0000, "conflict_a");
        fetch(32'h0000_0100, 1, 32'h2222_0100, "conflict_b");
        fetch(32'h0000_0000, 3, 32'h3333_0000, "conflict_a_again");
    endtask

    task automatic test_rollback();
        // Rollback wins over a lookup of a cached address in IDLE
        fet_address_in  = 32'h0000_0004;
        fet_request_in  = 1'b1;
        rob_rollback_in = 1'b1;
        step();
        rob_rollback_in = 1'b0;
        fet_request_in  = 1'b0;
        checks++;
        if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rollback_idle: ready=%b mc_req=%b want 0/0", fet_ready_out, mc_request_out);
        end
        step();
        checks++;
        if (fet_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rollback_idle late: ready=%b want 0", fet_ready_out);
        end

        // Rollback two cycles into a miss
        fet_address_in = 32'h0000_0010;
        fet_request_in = 1'b1;
        step();
        step();
        rob_rollback_in = 1'b1;
        fet_request_in  = 1'b0;
        step();
        rob_rollback_in = 1'b0;
        checks++;
        if (mc_request_out !== 1'b0 || fet_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rollback_miss: mc_req=%b ready=%b want 0/0", mc_request_out, fet_ready_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mc_request_out !== 1'b0 || fet_ready_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rollback_miss quiet: mc_req=%b ready=%b want 0/0", mc_request_out, fet_ready_out);
            end
        end
        fetch(32'h0000_0010, 2, 32'h4444_0010, "rerequest_after_rollback");

        // Rollback coincident with memory return: no fill, no response
        fet_address_in = 32'h0000_0020;
        fet_request_in = 1'b1;
        step();
        step();
        mc_ready_in       = 1'b1;
        mc_instruction_in = 32'h5555_0020;
        rob_rollback_in   = 1'b1;
        fet_request_in    = 1'b0;
        step();
        mc_ready_in     = 1'b0;
        rob_rollback_in = 1'b0;
        checks++;
        if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rollback_fill: ready=%b mc_req=%b want 0/0", fet_ready_out, mc_request_out);
        end
        step();
        checks++;
        if (fet_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rollback_fill late: ready=%b want 0", fet_ready_out);
        end
        fetch(32'h0000_0020, 1, 32'h6666_0020, "refetch_after_dropped_fill");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int li     = lineOf(32'h0000_0004);
        fet_address_in = 32'h0000_0004;
        fet_request_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fet_ready_out === 1'b1) pulses++;
            checks++;
            if (fet_ready_out !== ((i % 2) == 0) || mc_request_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL held_request cycle %0d: ready=%b mc_req=%b want %b/0",
                         i, fet_ready_out, mc_request_out, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                checks++;
                if (fet_instruction_out !== modelData[li]) begin
                    errors++;
                    $display("[TB] FAIL held_request data: got %h want %h", fet_instruction_out, modelData[li]);
                end
            end
        end
        fet_request_in = 1'b0;
        step();
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("[TB] FAIL held_request pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_miss();
        fet_address_in = 32'h0000_0040;
        fet_request_in = 1'b1;
        step();
        checks++;
        if (mc_request_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_miss pre: mc_req=%b want 1", mc_request_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mc_request_out !== 1'b0 || mc_address_out !== 32'h0 ||
            fet_ready_out !== 1'b0 || fet_instruction_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_miss async: mc_req=%b addr=%h ready=%b instr=%h want all 0",
                     mc_request_out, mc_address_out, fet_ready_out, fet_instruction_out);
        end
        for (int i = 0; i < 64; i++) modelValid[i] = 1'b0;
        fet_request_in = 1'b0;
        step();
        rst               = 1'b0;
        mc_ready_in       = 1'b1;
        mc_instruction_in = 32'h7777_0040;
        step();
        mc_ready_in = 1'b0;
        checks++;
        if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray mc_ready: ready=%b mc_req=%b want 0/0", fet_ready_out, mc_request_out);
        end
        fetch(32'h0000_0004, 1, 32'h0040_0093, "miss_after_reset");
        fetch(32'h0000_0040, 0, 32'h8888_0040, "fill_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
                   32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) addr = addr | ($urandom & 32'hFFFC_0000);
            fetch(addr, int'($urandom_range(0, 4)), $urandom, "random");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_rollback();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter INDEX_BITS, default 6, meaning: log2 of line count (64 lines, one 32-bit word per line).
REQ-002 Tag width SHALL be 16-INDEX_BITS bits; only address bits [17:0] are significant.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rob_rollback_in  input  1  misprediction flush; abort any outstanding fetch.
REQ-006 fet_request_in  input  1  fetcher requests instruction; held high until fet_ready_out seen.
REQ-007 fet_address_in  input  32  fetch PC; bits [1:0] ignored.
REQ-008 fet_ready_out  output  1  one-cycle pulse, fet_instruction_out valid.
REQ-009 fet_instruction_out  output  32  instruction word for the accepted request.
REQ-010 mc_request_out  output  1  word-read request to memory controller, held until mc_ready_in.
REQ-011 mc_address_out  output  32  word-aligned miss address ({fet_address_in[31:2],2'b00} latched).
REQ-012 mc_ready_in  input  1  memory controller read complete pulse.
REQ-013 mc_instruction_in  input  32  fetched word, valid when mc_ready_in=1.

Function
REQ-014 Organisation SHALL be direct-mapped: index = addr[INDEX_BITS+1:2], tag = addr[17:INDEX_BITS+2], per-line valid bit.
REQ-015 FSM states SHALL be IDLE, MISS, RESPOND.
REQ-016 IDLE, fet_request_in=1, valid&&tag match (hit): latch data to fet_instruction_out; next state RESPOND.
REQ-017 IDLE, fet_request_in=1, miss: latch address, index, tag; assert mc_request_out from next cycle; next state MISS.
REQ-018 MISS: mc_request_out=1 and mc_address_out stable every cycle until mc_ready_in=1.
REQ-019 MISS, mc_ready_in=1: write mc_instruction_in, tag, valid=1 into indexed line; latch word to fet_instruction_out; deassert mc_request_out next cycle; next state RESPOND.
REQ-020 RESPOND: fet_ready_out=1 for exactly this one cycle; fet_request_in ignored; next state IDLE.
REQ-021 Latency: hit request at cycle t -> fet_ready_out at t+1; miss -> fet_ready_out one cycle after mc_ready_in.
REQ-022 fet_ready_out SHALL be 0 in IDLE and MISS.
REQ-023 rob_rollback_in=1 in any state: next state IDLE, fet_ready_out=0 and mc_request_out=0 next cycle, request in flight discarded.
REQ-024 rob_rollback_in=1 coincident with mc_ready_in=1: no line fill, no response.
REQ-025 rob_rollback_in=1 coincident with fet_request_in=1 in IDLE: rollback wins, request not looked up that cycle.
REQ-026 Fill overwrites any previous line at same index (conflict eviction); no other replacement policy.
REQ-027 Valid bits SHALL never be cleared except by reset; rollback does not invalidate lines.
REQ-028 Only one outstanding miss; no new lookup until returning to IDLE.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, all valid bits 0, fet_ready_out=0, fet_instruction_out=0, mc_request_out=0, mc_address_out=0.
REQ-030 Reset asserted mid-MISS SHALL drop the request; a later mc_ready_in while in IDLE SHALL be ignored.
REQ-031 Data and tag arrays need no reset value; valid bits gate their use.

Verification
REQ-032 Cold miss: after reset, request 0x0000_0004 -> mc_request_out=1, mc_address_out=0x0000_0004; mc returns 0x0040_0093 after 5 cycles -> fet_ready_out pulse, fet_instruction_out=0x0040_0093.
REQ-033 Hit: re-request 0x0000_0004 -> fet_ready_out at next cycle with 0x0040_0093, mc_request_out stays 0.
REQ-034 Conflict: fill 0x0000_0000, then request 0x0000_0100 (same index, INDEX_BITS=6) -> miss; then 0x0000_0000 -> miss again.
REQ-035 Rollback during MISS: request 0x0000_0010, assert rob_rollback_in 2 cycles later -> mc_request_out=0 next cycle, no fet_ready_out; re-request 0x0000_0010 -> miss again.
REQ-036 Rollback coincident with mc_ready_in: no fill, no fet_ready_out; subsequent same address -> miss.
REQ-037 Held request: fet_request_in high through RESPOND -> exactly one fet_ready_out pulse per lookup, lookup resumes in IDLE.
